// File: rtl/mem_dump_ctrl.sv
// rtl/mem_dump_ctrl.sv - halt-triggered instr/data memory dump controller, optional checksum under DUMP_CHECKSUM_EN
module mem_dump_ctrl #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 256,
    parameter int RD_LAT     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        halt,
    output logic        cpu_stall,
    output logic        dbg_own,
    output logic [31:0] imem_addr,
    output logic [31:0] dmem_addr,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [7:0]  out_index,
    output logic        out_region,
    output logic        done,
    output logic [31:0] checksum
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACQUIRE = 3'd1,
        ADDR    = 3'd2,
        WAIT    = 3'd3,
        EMIT    = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] LAT_LAST  = 2'(RD_LAT - 1);
    localparam logic [7:0] IMEM_LAST = 8'(IMEM_WORDS - 1);
    localparam logic [7:0] DMEM_LAST = 8'(DMEM_WORDS - 1);

    state_t     state, state_d;
    logic [7:0] index, index_d;
    logic       region, region_d;
    logic [1:0] cnt, cnt_d;
    logic       capture;
    logic       addr_active;

    // Next-state, word sequencing and read-latency counting
    always_comb begin
        state_d  = state;
        index_d  = index;
        region_d = region;
        cnt_d    = cnt;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (halt) begin
                    state_d  = ACQUIRE;
                    index_d  = 8'd0;
                    region_d = 1'b0;
                end
            end
            ACQUIRE: state_d = ADDR;
            ADDR: begin
                state_d = WAIT;
                cnt_d   = 2'd0;
            end
            WAIT: begin
                if (cnt == LAT_LAST) begin
                    state_d = EMIT;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt + 2'd1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (!region) begin
                        state_d = ADDR;
                        if (index == IMEM_LAST) begin
                            region_d = 1'b1;
                            index_d  = 8'd0;
                        end else begin
                            index_d = index + 8'd1;
                        end
                    end else if (index == DMEM_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = ADDR;
                        index_d = index + 8'd1;
                    end
                end
            end
            DONE: begin
                if (!halt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The address stays on the bus from ADDR until the word is accepted
    always_comb begin
        addr_active = (state_d == ADDR) || (state_d == WAIT) || (state_d == EMIT);
    end

    // State register; all control outputs registered from the next state
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            index     <= 8'd0;
            region    <= 1'b0;
            cnt       <= 2'd0;
            cpu_stall <= 1'b0;
            dbg_own   <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            imem_addr <= 32'd0;
            dmem_addr <= 32'd0;
            out_data  <= 32'd0;
        end else begin
            state     <= state_d;
            index     <= index_d;
            region    <= region_d;
            cnt       <= cnt_d;
            cpu_stall <= (state_d != IDLE);
            dbg_own   <= (state_d != IDLE) && (state_d != DONE);
            done      <= (state_d == DONE);
            out_valid <= (state_d == EMIT);
            imem_addr <= (addr_active && !region_d) ? {22'd0, index_d, 2'b00} : 32'd0;
            dmem_addr <= (addr_active && region_d)  ? {22'd0, index_d, 2'b00} : 32'd0;
            if (capture) out_data <= region ? dmem_rdata : imem_rdata;
        end
    end

    assign out_index  = index;
    assign out_region = region;

`ifdef DUMP_CHECKSUM_EN
    logic [31:0] sum;

    // Running sum of accepted words, restarted when a dump begins
    always_ff @(posedge clock) begin
        if (!reset) begin
            sum <= 32'd0;
        end else if (state == IDLE && state_d != IDLE) begin
            sum <= 32'd0;
        end else if (state == EMIT && out_ready) begin
            sum <= sum + out_data;
        end
    end

    assign checksum = sum;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: doc/mem_dump_ctrl.md
MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 64, instruction-memory words dumped.
REQ-002 SHALL have parameter DMEM_WORDS, default 256, data-memory words dumped.
REQ-003 SHALL have parameter RD_LAT, default 1, memory read latency in cycles (1..4).
REQ-004 SHALL have port clock  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port halt  input  1  CPU finished program (level).
REQ-007 SHALL have port cpu_stall  output  1  freezes CPU pipeline while controller owns memories.
REQ-008 SHALL have port dbg_own  output  1  memory address mux select: 1 = controller, 0 = CPU.
REQ-009 SHALL have port imem_addr  output  32  byte address to instruction memory.
REQ-010 SHALL have port dmem_addr  output  32  byte address to data memory.
REQ-011 SHALL have ports imem_rdata and dmem_rdata  input  32 each  memory read data.
REQ-012 SHALL have ports out_valid  output  1, out_ready  input  1, out_data  output  32, out_index  output  8, out_region  output  1 (0 = instr, 1 = data).
REQ-013 SHALL have port done  output  1  full dump complete.
REQ-014 SHALL have port checksum  output  32  dump checksum (see Configuration).

Function
REQ-015 SHALL implement states IDLE, ACQUIRE, ADDR, WAIT, EMIT, DONE.
REQ-016 IDLE: halt sampled high -> ACQUIRE; region=0, index=0; halt low -> stay.
REQ-017 ACQUIRE: assert cpu_stall and dbg_own; next cycle -> ADDR (one quiesce cycle).
REQ-018 ADDR: drive selected region address = index<<2 (other region's address held 0); -> WAIT.
REQ-019 WAIT: hold address for RD_LAT cycles; capture selected rdata into out_data on leaving edge; -> EMIT.
REQ-020 EMIT: out_valid=1; out_data/out_index/out_region stable until out_valid&&out_ready sampled high.
REQ-021 On EMIT handshake: index<IMEM_WORDS-1 (region 0) or <DMEM_WORDS-1 (region 1) -> index+1, ADDR; last instr word -> region=1, index=0, ADDR; last data word -> DONE.
REQ-022 out_valid SHALL be registered; no combinational path from out_ready to any output.
REQ-023 First out_valid SHALL rise the cycle after edge N+2+RD_LAT, N = edge sampling halt in IDLE; with out_ready held high each word takes RD_LAT+2 cycles.
REQ-024 halt deasserting during ACQUIRE..EMIT SHALL be ignored; dump runs to completion.
REQ-025 DONE: done=1, cpu_stall=1, dbg_own=0; halt low -> IDLE with done=0, cpu_stall=0.
REQ-026 cpu_stall and dbg_own SHALL be 1 in every state except IDLE (dbg_own also 0 in DONE).

Reset
REQ-027 reset low at a rising edge SHALL force IDLE, index=0, region=0 at that edge, from any state.
REQ-028 Reset values: out_valid=0, done=0, cpu_stall=0, dbg_own=0, imem_addr=0, dmem_addr=0, out_data=0, out_index=0, out_region=0, checksum=0.
REQ-029 Reset mid-dump SHALL release memories at that edge; no partial word emitted after reset.

Configuration
REQ-030 Macro DUMP_CHECKSUM_EN defined: checksum = 32-bit wrapping sum of all handshaken out_data, cleared on leaving IDLE, final value stable in DONE.
REQ-031 Macro DUMP_CHECKSUM_EN undefined: no checksum logic; checksum tied to 0.

Verification
REQ-032 Halt pulse, out_ready=1, RD_LAT=1, memories filled word[i]=i: exactly 320 handshakes, instr indices 0..63 then data 0..255, out_data=i, done after last.
REQ-033 out_ready toggled pseudo-randomly: no word lost/duplicated, out_data stable while out_valid&&!out_ready.
REQ-034 reset low during data-region word 100: next cycle out_valid=0, dbg_own=0, cpu_stall=0, state IDLE; re-halt restarts from instr index 0.
REQ-035 halt dropped during instr index 10: dump completes all 320 words, then returns to IDLE one cycle after done.
REQ-036 DUMP_CHECKSUM_EN, word[i]=i both memories: checksum in DONE = 2016+32640 = 34656 (0x00008760).
REQ-037 RD_LAT=3: first out_valid 5 cycles after halt sampled edge; per-word spacing 5 cycles with out_ready=1.
